rr_hold_arbiter: RTL

Round-robin arbiter with grant hold and a bounded tenure. It shares one resource among `N` requesters (default 5, matching the existing 5-agent fixed-priority arbiter). A grant stays with its owner while the owner keeps requesting, up to `MAX_HOLD` cycles, and then rotates to the next requester. This gives fairness and bounded latency for every agent, where fixed priority can starve the low-priority agents.

---
 rtl/rr_hold_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter: a grant is held while its owner keeps requesting, for at most
// MAX_HOLD cycles, then rotates to the next requester with no idle gap.
module rr_hold_arbiter #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 4,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           gnt_last
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold_cnt;
  logic [IDW-1:0] rel_ptr;
  logic [IDW-1:0] idle_win;
  logic [IDW-1:0] rel_win;
  logic           idle_found;
  logic           rel_found;
  logic           hold_more;

  // Returns {found, index} of the first set request scanning from start, wrapping modulo N.
  function automatic logic [IDW:0] search(input logic [N-1:0] r, input logic [IDW-1:0] start);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (r[idx]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  // gnt_id doubles as the owner register; it is only meaningful while busy.
  assign rel_ptr   = (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
  assign {idle_found, idle_win} = search(req, ptr);
  assign {rel_found, rel_win}   = search(req, rel_ptr);
  assign hold_more = req[gnt_id] && (hold_cnt < HW'(MAX_HOLD));
  assign gnt_last  = busy && (hold_cnt == HW'(MAX_HOLD));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_found) begin
            state    <= GRANT;
            gnt      <= {{(N-1){1'b0}}, 1'b1} << idle_win;
            gnt_id   <= idle_win;
            busy     <= 1'b1;
            hold_cnt <= HW'(1);
          end
        end
        GRANT: begin
          if (hold_more) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            // Release: the search restarts just past the old owner, so a sole
            // requester wraps back to itself and keeps the grant without a gap.
            ptr <= rel_ptr;
            if (rel_found) begin
              gnt      <= {{(N-1){1'b0}}, 1'b1} << rel_win;
              gnt_id   <= rel_win;
              hold_cnt <= HW'(1);
            end else begin
              state    <= IDLE;
              gnt      <= '0;
              busy     <= 1'b0;
              hold_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
